// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave register bank: C_NUM_REGS 32-bit software registers written and
// read by the PPC over OPB, exported to fabric as a flat vector with a
// per-register write strobe. Registers flagged in C_PULSE_MASK hold a written
// value for a single cycle and then fall back to C_RESET_VAL.
// OPB buses are big-endian numbered (bit 0 = MSB); internally everything is
// little-endian, so DBus[0] maps to bit 31 and BE[0] to the top byte.
module opb_register_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 4,
    parameter logic [63:0] C_PULSE_MASK = 64'h0,
    parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    input  logic [0:31]               OPB_ABus,
    input  logic [0:3]                OPB_BE,
    input  logic [0:31]               OPB_DBus,
    input  logic                      OPB_RNW,
    input  logic                      OPB_select,
    input  logic                      OPB_seqAddr,
    output logic [0:31]               Sl_DBus,
    output logic                      Sl_xferAck,
    output logic                      Sl_errAck,
    output logic                      Sl_retry,
    output logic                      Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    output logic [C_NUM_REGS-1:0]     user_wr_strobe
);

    localparam int          IDX_W = (C_NUM_REGS > 1) ? $clog2(C_NUM_REGS) : 1;
    localparam logic [31:0] SPAN  = C_HIGHADDR - C_BASEADDR;

    // Elaboration-time sanity checks on the configuration.
    if (C_OPB_DWIDTH != 32) begin : g_bad_dwidth
        $error("opb_register_bank_ppc2simulink: only C_OPB_DWIDTH=32 is supported");
    end
    if (C_OPB_AWIDTH != 32) begin : g_bad_awidth
        $error("opb_register_bank_ppc2simulink: only C_OPB_AWIDTH=32 is supported");
    end
    if (C_NUM_REGS < 1 || C_NUM_REGS > 64) begin : g_bad_nregs
        $error("opb_register_bank_ppc2simulink: C_NUM_REGS must be 1..64");
    end
    if ((C_HIGHADDR < C_BASEADDR) ||
        (({1'b0, SPAN} + 33'd1) < 33'(4 * C_NUM_REGS))) begin : g_bad_window
        $error("opb_register_bank_ppc2simulink: address window too small for C_NUM_REGS");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 state_q, state_d;

    logic [31:0]            addr;
    logic [31:0]            wdata_bus;
    logic [3:0]             be_bus;
    logic [32:0]            diff;
    logic                   in_win;
    logic                   hit;
    logic                   idx_ok;

    logic [IDX_W-1:0]       idx_q;
    logic                   idx_ok_q;
    logic                   rnw_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;

    logic [31:0]            regs_q [C_NUM_REGS];
    logic [31:0]            regs_d [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  strobe_q, strobe_d;

    logic                   ack;
    logic                   wr_en;
    logic [31:0]            rdata;
    logic                   unused_ok;

    // Positional assignment turns big-endian bus numbering into little-endian.
    assign addr      = OPB_ABus;
    assign wdata_bus = OPB_DBus;
    assign be_bus    = OPB_BE;

    // Borrow out of the subtraction means the address is below the window.
    assign diff   = {1'b0, addr} - {1'b0, C_BASEADDR};
    assign in_win = !diff[32] && (diff[31:0] <= SPAN);
    assign hit    = OPB_select && in_win;
    assign idx_ok = (diff[31:2] < 30'(C_NUM_REGS));

    // Seed address bits below word granularity and seqAddr carry no meaning.
    assign unused_ok = &{1'b0, OPB_seqAddr, diff[1:0]};

    // FSM state register; reset drops any in-flight transfer.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one ack per select, then wait for select to drop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hit) state_d = ACK;
            ACK:     state_d = HOLD;
            HOLD:    if (!OPB_select) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture the transfer attributes when the access is accepted.
    always_ff @(posedge OPB_Clk) begin
        if (state_q == IDLE && hit) begin
            idx_q    <= diff[IDX_W+1:2];
            idx_ok_q <= idx_ok;
            rnw_q    <= OPB_RNW;
            be_q     <= be_bus;
            wdata_q  <= wdata_bus;
        end
    end

    assign ack   = (state_q == ACK);
    assign wr_en = ack && !rnw_q && idx_ok_q;

    // Read mux: pre-write register value, zero outside ACK to suit an OR bus.
    always_comb begin
        rdata = 32'h0;
        if (ack && rnw_q && idx_ok_q) begin
            rdata = regs_q[idx_q];
        end
    end

    // Register next-state: byte-masked write, or pulse-register fall-back.
    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (idx_q == IDX_W'(i))) begin
                strobe_d[i] = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (be_q[b]) begin
                        regs_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end else if (strobe_q[i] && C_PULSE_MASK[i]) begin
                regs_d[i] = C_RESET_VAL;
            end
        end
    end

    // Register bank and write strobes; strobe lines up with the new value.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= C_RESET_VAL;
            end
            strobe_q <= '0;
        end else begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            strobe_q <= strobe_d;
        end
    end

    // Flatten the bank for the fabric side.
    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            user_data_out[32*i +: 32] = regs_q[i];
        end
    end

    assign user_wr_strobe = strobe_q;
    assign Sl_DBus        = rdata;
    assign Sl_xferAck     = ack;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// Self-checking bench for opb_register_bank_ppc2simulink: directed vector
// table, randomized accesses against a register-array model, and hand-written
// sequences for held select, pulse registers and reset during ACK.
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] HIGH  = 32'h0000_10FF;
    localparam int          NREG  = 4;
    localparam logic [63:0] PULSE = 64'h1;
    localparam logic [31:0] RSTV  = 32'h0000_0000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:31]   abus;
    logic [0:3]    be;
    logic [0:31]   dbus;
    logic          rnw;
    logic          sel;
    logic          seq;
    logic [0:31]   sl_dbus;
    logic          ack;
    logic          err_ack;
    logic          retry;
    logic          tout;
    logic [127:0]  udo;
    logic [3:0]    strb;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mregs [NREG];

    logic          s_ack  [20];
    logic [3:0]    s_strb [20];
    logic [127:0]  s_udo  [20];
    logic [31:0]   s_dbus [20];
    int            n_s;

    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] data;
        int          hold;
        int          exp_ack;
        logic [31:0] exp_rd;
        logic [3:0]  exp_strb;
    } vec_t;

    vec_t tbl [12];

    opb_register_bank_ppc2simulink #(
        .C_BASEADDR   (BASE),
        .C_HIGHADDR   (HIGH),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_NUM_REGS   (NREG),
        .C_PULSE_MASK (PULSE),
        .C_RESET_VAL  (RSTV)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst_n      (rst_n),
        .OPB_ABus       (abus),
        .OPB_BE         (be),
        .OPB_DBus       (dbus),
        .OPB_RNW        (rnw),
        .OPB_select     (sel),
        .OPB_seqAddr    (seq),
        .Sl_DBus        (sl_dbus),
        .Sl_xferAck     (ack),
        .Sl_errAck      (err_ack),
        .Sl_retry       (retry),
        .Sl_toutSup     (tout),
        .user_data_out  (udo),
        .user_wr_strobe (strb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic logic [127:0] mflat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < NREG; i++) f[32*i +: 32] = mregs[i];
        return f;
    endfunction

    // Drive one transfer with select held for 'hold' sampled cycles, record outputs.
    task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b,
                        input logic [31:0] d, input int hold);
        @(posedge clk);
        #1;
        abus = a; rnw = r; be = b; dbus = d; sel = 1'b1;
        n_s = hold + 4;
        for (int k = 0; k < n_s; k++) begin
            @(negedge clk);
            s_ack[k]  = ack;
            s_strb[k] = strb;
            s_udo[k]  = udo;
            s_dbus[k] = sl_dbus;
            if (k == hold - 1) begin
                @(posedge clk);
                #1;
                sel = 1'b0;
            end
        end
    endtask

    // Run a transfer and compare everything against the register-array model.
    task automatic run(input string nm, input logic [31:0] a, input logic r,
                       input logic [3:0] b, input logic [31:0] d, input int hold,
                       output int ack_cnt, output logic [31:0] rd,
                       output logic [3:0] strb_or);
        logic        in_win, valid;
        int          idx, first, sk, strb_cnt;
        logic [31:0] exp_rd, newv;
        logic [3:0]  exp_strb;
        logic        dbus_bad;

        in_win = (a >= BASE) && (a <= HIGH);
        idx    = int'((a - BASE) >> 2);
        valid  = in_win && (idx < NREG);
        exp_rd = valid ? mregs[idx] : 32'h0;
        newv   = valid ? mregs[idx] : 32'h0;
        for (int q = 0; q < 4; q++) if (b[q]) newv[8*q +: 8] = d[8*q +: 8];
        exp_strb = (valid && !r) ? 4'(1 << idx) : 4'h0;

        xfer(a, r, b, d, hold);

        ack_cnt = 0; first = -1; sk = -1; strb_cnt = 0; dbus_bad = 1'b0;
        strb_or = 4'h0; rd = 32'h0;
        for (int k = 0; k < n_s; k++) begin
            if (s_ack[k]) begin
                ack_cnt++;
                if (first < 0) first = k;
                rd = s_dbus[k];
            end else if (s_dbus[k] != 32'h0) begin
                dbus_bad = 1'b1;
            end
            if (s_strb[k] != 4'h0) begin
                strb_cnt++;
                sk = k;
                strb_or |= s_strb[k];
            end
        end

        chk({nm, " ack_count"}, 128'(ack_cnt), 128'(in_win ? 1 : 0));
        if (in_win) chk({nm, " ack_latency"}, 128'(first), 128'(1));
        if (in_win && r) chk({nm, " rdata"}, 128'(rd), 128'(exp_rd));
        chk({nm, " dbus_idle_zero"}, 128'(dbus_bad), 128'(0));
        chk({nm, " strobe_count"}, 128'(strb_cnt), 128'(exp_strb != 0 ? 1 : 0));
        if (exp_strb != 4'h0 && strb_cnt == 1) begin
            chk({nm, " strobe_value"}, 128'(strb_or), 128'(exp_strb));
            chk({nm, " strobe_timing"}, 128'(sk), 128'(first + 1));
            chk({nm, " udo_at_strobe"}, 128'(s_udo[sk][32*idx +: 32]), 128'(newv));
            if (PULSE[idx]) chk({nm, " pulse_clear"}, 128'(s_udo[sk+1][32*idx +: 32]), 128'(RSTV));
        end

        if (valid && !r) mregs[idx] = PULSE[idx] ? RSTV : newv;
        chk({nm, " udo_final"}, s_udo[n_s-1], mflat());
    endtask

    initial begin
        int          ac;
        logic [31:0] rd;
        logic [3:0]  so;
        int          waited;
        logic [31:0] ra;

        rst_n = 1'b0; sel = 1'b0; seq = 1'b0; rnw = 1'b0;
        abus = '0; be = '0; dbus = '0;
        for (int i = 0; i < NREG; i++) mregs[i] = RSTV;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset ack", 128'(ack), 128'(0));
        chk("reset dbus", 128'(sl_dbus), 128'(0));
        chk("reset udo", udo, mflat());
        chk("reset strobe", 128'(strb), 128'(0));
        chk("tieoffs", 128'({err_ack, retry, tout}), 128'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vectors: addr, rnw, be, data, hold, exp_ack, exp_rd, exp_strb
        tbl[0]  = '{BASE + 32'h08, 1'b0, 4'hF, 32'hDEADBEEF, 2, 1, 32'h0,        4'b0100};
        tbl[1]  = '{BASE + 32'h04, 1'b0, 4'hF, 32'h11223344, 2, 1, 32'h0,        4'b0010};
        tbl[2]  = '{BASE + 32'h04, 1'b0, 4'h5, 32'hAABBCCDD, 2, 1, 32'h0,        4'b0010};
        tbl[3]  = '{BASE + 32'h04, 1'b1, 4'hF, 32'h0,        2, 1, 32'h11BB33DD, 4'b0000};
        tbl[4]  = '{BASE + 32'h08, 1'b1, 4'hF, 32'h0,        3, 1, 32'hDEADBEEF, 4'b0000};
        tbl[5]  = '{BASE + 32'h40, 1'b1, 4'hF, 32'h0,        2, 1, 32'h0,        4'b0000};
        tbl[6]  = '{BASE + 32'h40, 1'b0, 4'hF, 32'hFFFFFFFF, 2, 1, 32'h0,        4'b0000};
        tbl[7]  = '{HIGH + 32'h04, 1'b1, 4'hF, 32'h0,        4, 0, 32'h0,        4'b0000};
        tbl[8]  = '{BASE - 32'h04, 1'b0, 4'hF, 32'h5A5A5A5A, 4, 0, 32'h0,        4'b0000};
        tbl[9]  = '{BASE + 32'h0C, 1'b0, 4'h0, 32'h12345678, 2, 1, 32'h0,        4'b1000};
        tbl[10] = '{BASE + 32'h00, 1'b0, 4'hF, 32'h00000001, 2, 1, 32'h0,        4'b0001};
        tbl[11] = '{BASE + 32'h00, 1'b1, 4'hF, 32'h0,        2, 1, 32'h0,        4'b0000};

        for (int i = 0; i < 12; i++) begin
            run($sformatf("vec%0d", i), tbl[i].addr, tbl[i].rnw, tbl[i].be,
                tbl[i].data, tbl[i].hold, ac, rd, so);
            chk($sformatf("vec%0d tbl_ack", i), 128'(ac), 128'(tbl[i].exp_ack));
            chk($sformatf("vec%0d tbl_strobe", i), 128'(so), 128'(tbl[i].exp_strb));
            if (tbl[i].rnw && tbl[i].exp_ack == 1)
                chk($sformatf("vec%0d tbl_rdata", i), 128'(rd), 128'(tbl[i].exp_rd));
        end

        // Select held for 10 cycles on one write: single ack, single strobe
        run("hold10", BASE + 32'h04, 1'b0, 4'hF, 32'hCAFEF00D, 10, ac, rd, so);
        chk("hold10 single_ack", 128'(ac), 128'(1));
        chk("hold10 strobe", 128'(so), 128'(4'b0010));

        // Randomized accesses against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5: ra = BASE + 32'(4 * $urandom_range(0, 5));
                6:       ra = BASE + 32'h40;
                7:       ra = HIGH + 32'h04;
                8:       ra = BASE - 32'h04;
                default: ra = HIGH - 32'h03;
            endcase
            run($sformatf("rnd%0d", i), ra, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom, $urandom_range(2, 4), ac, rd, so);
        end

        // Reset asserted while in ACK
        @(posedge clk);
        #1;
        abus = BASE + 32'h0C; rnw = 1'b0; be = 4'hF; dbus = 32'hAAAA5555; sel = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!ack && waited < 6);
        chk("rst_mid ack_reached", 128'(ack), 128'(1));
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) mregs[i] = RSTV;
        chk("rst_mid ack_drop", 128'(ack), 128'(0));
        chk("rst_mid udo", udo, mflat());
        chk("rst_mid strobe", 128'(strb), 128'(0));
        chk("rst_mid dbus", 128'(sl_dbus), 128'(0));
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid no_late_ack", 128'(ack), 128'(0));
        chk("rst_mid no_late_strobe", 128'(strb), 128'(0));
        chk("rst_mid udo_after", udo, mflat());
        run("post_rst_read", BASE + 32'h04, 1'b1, 4'hF, 32'h0, 2, ac, rd, so);
        run("post_rst_write", BASE + 32'h08, 1'b0, 4'hC, 32'h9876FEDC, 2, ac, rd, so);
        run("post_rst_readback", BASE + 32'h08, 1'b1, 4'hF, 32'h0, 2, ac, rd, so);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
